// File: rtl/spi_shift_engine_if.sv
// rtl/spi_shift_engine_if.sv - control, data and status bundle for the SPI shift engine
interface spi_shift_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
);
   logic                  ss;
   logic                  cpol;
   logic                  cphase;
   logic                  lsbfe;
   logic [CNT_W-1:0]      frame_len;
   logic                  send_data;
   logic [DATA_WIDTH-1:0] data_mosi;
   logic                  flag_low;
   logic                  flag_high;
   logic                  flags_low;
   logic                  flags_high;
   logic                  miso;
   logic                  receive_data;
   logic                  mosi;
   logic [DATA_WIDTH-1:0] data_miso;
   logic                  busy;
   logic                  rx_valid;
   logic                  rx_full;
   logic                  overrun;
   logic                  aborted;

   modport slave (
      input  ss, cpol, cphase, lsbfe, frame_len, send_data, data_mosi,
             flag_low, flag_high, flags_low, flags_high, miso, receive_data,
      output mosi, data_miso, busy, rx_valid, rx_full, overrun, aborted
   );

   modport master (
      output ss, cpol, cphase, lsbfe, frame_len, send_data, data_mosi,
             flag_low, flag_high, flags_low, flags_high, miso, receive_data,
      input  mosi, data_miso, busy, rx_valid, rx_full, overrun, aborted
   );
endinterface

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI bit shifter driven by external drive/sample strobes
module spi_shift_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
   input logic          PCLK,
   input logic          PRESETn,
   spi_shift_engine_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam logic [CNT_W-1:0]      FULL_LEN = CNT_W'(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
   logic                  mosi_q, mosi_d;
   logic                  rx_full_q, rx_full_d;
   logic                  overrun_q, overrun_d;
   logic                  aborted_q, aborted_d;

   logic                  hi_sel, drv_stb, smp_stb;
   logic [CNT_W-1:0]      eff_len, load_len;
   logic [DATA_WIDTH-1:0] load_data;

   // Both SPI bit orders map frame position to word index the same way for tx and rx
   function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] len,
                                                input logic             lsb_first);
      return lsb_first ? cnt : len - CNT_W'(1) - cnt;
   endfunction

   function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] word,
                                   input logic [CNT_W-1:0]      cnt,
                                   input logic [CNT_W-1:0]      len,
                                   input logic                  lsb_first);
      logic [DATA_WIDTH-1:0] sh;
      sh = word >> bit_idx(cnt, len, lsb_first);
      return sh[0];
   endfunction

   assign hi_sel    = bus.cpol ^ bus.cphase;
   assign drv_stb   = hi_sel ? bus.flags_high : bus.flags_low;
   assign smp_stb   = hi_sel ? bus.flag_high  : bus.flag_low;
   assign eff_len   = (bus.frame_len == '0 || bus.frame_len > FULL_LEN) ? FULL_LEN : bus.frame_len;
   assign load_data = bus.send_data ? bus.data_mosi : tx_shift_q;
   assign load_len  = bus.send_data ? eff_len : len_q;

   always_comb begin
      state_d    = state_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_buf_d   = rx_buf_q;
      len_d      = len_q;
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      mosi_d     = mosi_q;
      rx_full_d  = rx_full_q;
      overrun_d  = overrun_q;
      aborted_d  = 1'b0;

      if (bus.receive_data) begin
         rx_full_d = 1'b0;
         overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.send_data) begin
               tx_shift_d = bus.data_mosi;
               len_d      = eff_len;
               state_d    = ST_READY;
            end
         end
         ST_READY: begin
            tx_shift_d = load_data;
            len_d      = load_len;
            if (!bus.ss) begin
               state_d    = ST_SHIFT;
               rx_shift_d = '0;
               rx_cnt_d   = '0;
               tx_cnt_d   = '0;
               // cphase=0 needs the first bit on the line before any edge arrives
               if (!bus.cphase) begin
                  mosi_d   = tx_bit(load_data, '0, load_len, bus.lsbfe);
                  tx_cnt_d = CNT_W'(1);
               end
            end
         end
         ST_SHIFT: begin
            if (bus.ss) begin
               state_d   = ST_IDLE;
               tx_cnt_d  = '0;
               rx_cnt_d  = '0;
               aborted_d = 1'b1;
            end else begin
               if (drv_stb && tx_cnt_q < len_q) begin
                  mosi_d   = tx_bit(tx_shift_q, tx_cnt_q, len_q, bus.lsbfe);
                  tx_cnt_d = tx_cnt_q + CNT_W'(1);
               end
               if (smp_stb) begin
                  rx_shift_d = (rx_shift_q & ~(ONE << bit_idx(rx_cnt_q, len_q, bus.lsbfe)))
                             | ({{(DATA_WIDTH-1){1'b0}}, bus.miso} << bit_idx(rx_cnt_q, len_q, bus.lsbfe));
                  rx_cnt_d   = rx_cnt_q + CNT_W'(1);
                  // rx_shift was cleared at frame start, so bits at or above L are already zero
                  if (rx_cnt_d == len_q) begin
                     rx_buf_d = rx_shift_d;
                     state_d  = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
            rx_full_d = 1'b1;
            overrun_d = bus.receive_data ? overrun_q : (overrun_q | rx_full_q);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= ST_IDLE;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_buf_q   <= '0;
         len_q      <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         mosi_q     <= 1'b0;
         rx_full_q  <= 1'b0;
         overrun_q  <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_buf_q   <= rx_buf_d;
         len_q      <= len_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         mosi_q     <= mosi_d;
         rx_full_q  <= rx_full_d;
         overrun_q  <= overrun_d;
         aborted_q  <= aborted_d;
      end
   end

   assign bus.mosi      = mosi_q;
   assign bus.data_miso = bus.receive_data ? rx_buf_q : '0;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.rx_valid  = (state_q == ST_DONE);
   assign bus.rx_full   = rx_full_q;
   assign bus.overrun   = overrun_q;
   assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed and randomized frames against a queue-based SPI model
module tb_spi_shift_engine;
   localparam int DW = 16;
   localparam int CW = 5;

   logic PCLK = 1'b0;
   logic PRESETn;
   int   errors = 0;
   int   checks = 0;

   logic          model_full;
   logic          model_ovr;
   logic [DW-1:0] model_buf;

   spi_shift_engine_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

   spi_shift_engine #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .bus    (bus)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Optional noise cycle fires only the unselected strobes and a bogus load request
   task automatic pulse(input logic drv, input logic smp, input logic hi, input logic noise);
      if (noise) begin
         bus.flags_high = ~hi; bus.flags_low = hi; bus.flag_high = ~hi; bus.flag_low = hi;
         bus.send_data  = 1'b1;
         bus.data_mosi  = DW'($urandom);
         bus.frame_len  = CW'($urandom);
         tick();
         bus.send_data  = 1'b0;
      end
      bus.flags_high = drv & hi;
      bus.flags_low  = drv & ~hi;
      bus.flag_high  = smp & hi;
      bus.flag_low   = smp & ~hi;
      tick();
      bus.flags_high = 1'b0; bus.flags_low = 1'b0; bus.flag_high = 1'b0; bus.flag_low = 1'b0;
   endtask

   task automatic read_buf();
      bus.receive_data = 1'b1;
      #1;
      check("read_data", bus.data_miso, model_buf);
      tick();
      bus.receive_data = 1'b0;
      #1;
      model_full = 1'b0;
      model_ovr  = 1'b0;
      check("read_clr_full", bus.rx_full, model_full);
      check("read_clr_ovr", bus.overrun, model_ovr);
      check("miso_idle_zero", bus.data_miso, 0);
   endtask

   task automatic start_frame(input logic [DW-1:0] data, input int flen, input logic lsb,
                              input logic cpl, input logic cph);
      bus.cpol = cpl; bus.cphase = cph; bus.lsbfe = lsb;
      bus.frame_len = CW'(flen);
      bus.data_mosi = data;
      bus.send_data = 1'b1;
      tick();
      bus.send_data = 1'b0;
      check("ready_busy", bus.busy, 1);
   endtask

   task automatic run_frame(input logic [DW-1:0] data, input int flen, input logic lsb,
                            input logic cpl, input logic cph, input logic noise,
                            input logic both, input logic read_in_done);
      int            len;
      int            pos;
      logic          exp_bits[$];
      logic [DW-1:0] word;
      logic          hi;
      logic          prev_mosi;
      len = (flen == 0 || flen > DW) ? DW : flen;
      for (int i = 0; i < len; i++) begin
         pos = lsb ? i : len - 1 - i;
         exp_bits.push_back(data[pos]);
      end
      word = DW'(32'(data) & ((32'd1 << len) - 32'd1));
      hi   = cpl ^ cph;

      start_frame(data, flen, lsb, cpl, cph);
      prev_mosi = bus.mosi;
      bus.ss = 1'b0;
      tick();
      if (!cph) check("preload", bus.mosi, exp_bits[0]);
      else      check("no_preload", bus.mosi, prev_mosi);

      for (int i = 0; i < len; i++) begin
         if (cph) begin
            pulse(1'b1, 1'b0, hi, noise);
            check("drive_bit", bus.mosi, exp_bits[i]);
         end
         bus.miso = bus.mosi;
         if (!cph && both && i < len - 1) begin
            pulse(1'b1, 1'b1, hi, noise);
            check("both_drive", bus.mosi, exp_bits[i+1]);
            check("both_no_valid", bus.rx_valid, 0);
         end else begin
            pulse(1'b0, 1'b1, hi, noise);
            check("rx_valid", bus.rx_valid, (i == len - 1) ? 1 : 0);
            if (!cph && i < len - 1) begin
               pulse(1'b1, 1'b0, hi, noise);
               check("drive_bit", bus.mosi, exp_bits[i+1]);
            end
         end
      end

      // Now in the single completion cycle
      bus.receive_data = read_in_done;
      bus.send_data    = noise;
      bus.data_mosi    = DW'($urandom);
      #1;
      if (read_in_done) check("done_read_data", bus.data_miso, word);
      tick();
      bus.receive_data = 1'b0;
      bus.send_data    = 1'b0;
      model_buf = word;
      if (!read_in_done) model_ovr = model_ovr | model_full;
      model_full = 1'b1;
      check("valid_one_cycle", bus.rx_valid, 0);
      check("idle_after_done", bus.busy, 0);
      check("rx_full", bus.rx_full, model_full);
      check("overrun", bus.overrun, model_ovr);
      bus.ss = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mosi"}, bus.mosi, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_valid"}, bus.rx_valid, 0);
      check({tag, "_full"}, bus.rx_full, 0);
      check({tag, "_ovr"}, bus.overrun, 0);
      check({tag, "_abort"}, bus.aborted, 0);
      bus.receive_data = 1'b1;
      #1;
      check({tag, "_buf"}, bus.data_miso, 0);
      bus.receive_data = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          held;
      bus.ss = 1'b1; bus.cpol = 1'b0; bus.cphase = 1'b0; bus.lsbfe = 1'b0;
      bus.frame_len = '0; bus.send_data = 1'b0; bus.data_mosi = '0;
      bus.flag_low = 1'b0; bus.flag_high = 1'b0; bus.flags_low = 1'b0; bus.flags_high = 1'b0;
      bus.miso = 1'b0; bus.receive_data = 1'b0;
      model_full = 1'b0; model_ovr = 1'b0; model_buf = '0;
      PRESETn = 1'b0;
      tick(); tick();
      check_reset_outputs("reset");
      PRESETn = 1'b1;
      tick();

      // Mode 0 LSB-first 0xA5, mode 1 full-width MSB-first, mode 2 five-bit frame
      run_frame(16'h00A5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      read_buf();
      run_frame(16'hC3F0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      read_buf();
      run_frame(16'hFF13, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      read_buf();

      // Overrun from two unread frames, then a read that lands on completion
      run_frame(DW'($urandom), 12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(DW'($urandom), 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      read_buf();
      run_frame(DW'($urandom), 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_frame(DW'($urandom), 10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      read_buf();

      for (int n = 0; n < 8; n++) begin
         run_frame(DW'($urandom), int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         read_buf();
      end

      // Abort after three samples
      start_frame(DW'($urandom), 8, 1'b1, 1'b0, 1'b0);
      bus.ss = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.miso = ~bus.mosi;
         pulse(1'b0, 1'b1, 1'b0, 1'b0);
         pulse(1'b1, 1'b0, 1'b0, 1'b0);
      end
      held = bus.mosi;
      bus.ss = 1'b1;
      tick();
      check("abort_pulse", bus.aborted, 1);
      check("abort_idle", bus.busy, 0);
      check("abort_no_valid", bus.rx_valid, 0);
      check("abort_mosi_hold", bus.mosi, held);
      tick();
      check("abort_one_cycle", bus.aborted, 0);
      check("abort_no_valid2", bus.rx_valid, 0);
      read_buf();

      // Asynchronous reset in the middle of a frame, with rx_full set beforehand
      run_frame(DW'($urandom), 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rd = DW'($urandom);
      start_frame(rd | DW'(1), 8, 1'b1, 1'b0, 1'b0);
      bus.ss = 1'b0;
      tick();
      bus.miso = 1'b1;
      pulse(0, 1, 0, 0);
      #2;
      PRESETn = 1'b0;
      #1;
      model_full = 1'b0; model_ovr = 1'b0; model_buf = '0;
      check_reset_outputs("midreset");
      tick();
      PRESETn = 1'b1;
      bus.ss = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post_reset_no_valid", bus.rx_valid, 0);
      end
      run_frame(DW'($urandom), 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      read_buf();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
